// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU execution unit.
// Control codes, FSM states and main-control alu_op encodings.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SLT = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_MUL = 4'd7
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam logic [1:0] OP_FUNC = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_ADD  = 2'b11;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Maps (alu_op, func) to the internal ALU control code.
// Build option ALU_MUL_EN: when undefined, func 7 decodes as ADD.
import alu_seq_pkg::*;

module alu_ctrl_decode #(
  parameter int FUNC_W = 4
) (
  input  logic [1:0]        i_alu_op,
  input  logic [FUNC_W-1:0] i_func,
  output alu_ctrl_e         o_ctrl
);

  always_comb begin
    o_ctrl = ALU_ADD;
    unique case (1'b1)
      (i_alu_op == OP_ADD): o_ctrl = ALU_ADD;
      (i_alu_op == OP_SUB): o_ctrl = ALU_SUB;
      (i_alu_op == OP_AND): o_ctrl = ALU_AND;
      default: begin
        // func values above 7 fall back to ADD
        if ((i_func >> 3) == '0)
          o_ctrl = alu_ctrl_e'({1'b0, i_func[2:0]});
      end
    endcase
`ifndef ALU_MUL_EN
    if (o_ctrl == ALU_MUL)
      o_ctrl = ALU_ADD;
`endif
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with single-cycle ops, bit-serial shifts and
// optional shift-add multiply (build option ALU_MUL_EN).
import alu_seq_pkg::*;

module alu_seq_unit #(
  parameter  int WIDTH   = 32,
  parameter  int FUNC_W  = 4,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [FUNC_W-1:0] func,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic              zero,
  output logic              busy
);

  localparam int CNT_W = SHAMT_W + 1;

  alu_state_e       r_state;
  alu_ctrl_e        r_ctrl;
  logic [WIDTH-1:0] r_a;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
`endif

  alu_ctrl_e          w_ctrl;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_multi;
  logic               w_fire;
  logic [WIDTH-1:0]   w_step_a;
  logic [WIDTH-1:0]   w_fin;

  alu_ctrl_decode #(
    .FUNC_W (FUNC_W)
  ) u_dec (
    .i_alu_op (alu_op),
    .i_func   (func),
    .o_ctrl   (w_ctrl)
  );

  assign w_shamt   = b[SHAMT_W-1:0];
  assign w_fire    = in_valid & in_ready;
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign result    = r_result;
  assign zero      = r_zero;

  always_comb begin
    w_alu = a + b;
    unique case (w_ctrl)
      ALU_SUB: w_alu = a - b;
      ALU_AND: w_alu = a & b;
      ALU_OR:  w_alu = a | b;
      ALU_SLT: w_alu = {{(WIDTH-1){1'b0}},
                        ($signed(a) < $signed(b))};
      ALU_SLL: w_alu = a;
      ALU_SRL: w_alu = a;
      default: w_alu = a + b;
    endcase
  end

  always_comb begin
    w_multi = ((w_ctrl == ALU_SLL) || (w_ctrl == ALU_SRL))
              && (w_shamt != '0);
`ifdef ALU_MUL_EN
    if (w_ctrl == ALU_MUL)
      w_multi = 1'b1;
`endif
  end

  assign w_step_a = (r_ctrl == ALU_SRL) ? (r_a >> 1) : (r_a << 1);

`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] w_acc_nxt;
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
  assign w_fin = (r_ctrl == ALU_MUL) ? w_acc_nxt : w_step_a;
`else
  assign w_fin = w_step_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= ALU_ADD;
      r_a      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
`ifdef ALU_MUL_EN
      r_b      <= '0;
      r_acc    <= '0;
`endif
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_fire) begin
            r_ctrl <= w_ctrl;
            r_a    <= a;
            if (w_multi) begin
              r_cnt   <= {1'b0, w_shamt};
              r_state <= ST_EXEC;
`ifdef ALU_MUL_EN
              r_b   <= b;
              r_acc <= '0;
              if (w_ctrl == ALU_MUL)
                r_cnt <= CNT_W'(WIDTH);
`endif
            end else begin
              r_result <= w_alu;
              r_zero   <= (w_alu == '0);
              r_state  <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          r_a   <= w_step_a;
          r_cnt <= r_cnt - 1'b1;
`ifdef ALU_MUL_EN
          r_b   <= r_b >> 1;
          r_acc <= w_acc_nxt;
`endif
          // last iteration lands directly in the result register
          if (r_cnt == CNT_W'(1)) begin
            r_result <= w_fin;
            r_zero   <= (w_fin == '0);
            r_state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
